// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single write port of the 32 x 32-bit register file.
// Held requests compete; the winner gets a one-cycle grant and its address/data
// are registered straight onto the register-file write port. Writes aimed at
// register 0 are granted but carry WE=0, so R0 stays hard-wired to zero.
module regfile_wr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [N-1:0]      Req,
   input  logic [5*N-1:0]    Req_Addr,
   input  logic [32*N-1:0]   Req_Data,
   input  logic              Stall,
   output logic [N-1:0]      Gnt,
   output logic              WE,
   output logic [4:0]        Addr,
   output logic [31:0]       Data
);

   // Registered state and its next-state values
   logic [PTR_W-1:0] ptr_q,  ptr_d;
   logic [N-1:0]     gnt_q,  gnt_d;
   logic             we_q,   we_d;
   logic [4:0]       addr_q, addr_d;
   logic [31:0]      data_q, data_d;

   // Arbitration intermediates
   logic [N-1:0]     eligible;
   logic             found;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W:0]   cand;
   logic [N-1:0]     win_onehot;
   logic [4:0]       win_addr;
   logic [31:0]      win_data;
   logic [PTR_W-1:0] ptr_nxt;

   // Find the first eligible requester scanning from ptr, wrapping modulo N
   always_comb begin
      // NOTE: every comb output gets a default up front so no path leaves it unassigned (no latch).
      eligible = Req & ~gnt_q;
      found    = 1'b0;
      win_idx  = '0;
      cand     = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(N)) begin
            cand = cand - (PTR_W+1)'(N);
         end
         if (!found && eligible[cand[PTR_W-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[PTR_W-1:0];
         end
      end
   end

   // Select the winner's address/data and build its one-hot grant
   always_comb begin
      win_onehot = '0;
      win_addr   = '0;
      win_data   = '0;
      for (int i = 0; i < N; i++) begin
         if (win_idx == PTR_W'(i)) begin
            win_onehot[i] = 1'b1;
            win_addr      = Req_Addr[5*i +: 5];
            win_data      = Req_Data[32*i +: 32];
         end
      end
      ptr_nxt = (win_idx == PTR_W'(N-1)) ? '0 : win_idx + PTR_W'(1);
   end

   // Next-state: grant when something is eligible and the port is not stalled
   always_comb begin
      gnt_d  = '0;
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      ptr_d  = ptr_q;
      if (found && !Stall) begin
         gnt_d  = win_onehot;
         we_d   = (win_addr != 5'd0);
         addr_d = win_addr;
         data_d = win_data;
         ptr_d  = ptr_nxt;
      end
   end

   // State register with synchronous reset; reset drops any pending write
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (Rst) begin
         ptr_q  <= '0;
         gnt_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         gnt_q  <= gnt_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign Gnt  = gnt_q;
   assign WE   = we_q;
   assign Addr = addr_q;
   assign Data = data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed stimulus pushes the
// expected grant (cycle, Gnt, WE, Addr, Data) into a queue; a monitor pops and
// compares whenever the DUT shows a grant or write enable.
module tb_regfile_wr_arbiter;

   localparam int N = 4;

   logic            Clk;
   logic            Rst;
   logic [N-1:0]    Req;
   logic [5*N-1:0]  Req_Addr;
   logic [32*N-1:0] Req_Data;
   logic            Stall;
   logic [N-1:0]    Gnt;
   logic            WE;
   logic [4:0]      Addr;
   logic [31:0]     Data;

   regfile_wr_arbiter #(.N(N), .PTR_W(2)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Req      (Req),
      .Req_Addr (Req_Addr),
      .Req_Data (Req_Data),
      .Stall    (Stall),
      .Gnt      (Gnt),
      .WE       (WE),
      .Addr     (Addr),
      .Data     (Data)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  gnt;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [4:0]  ta[N];
   logic [31:0] td[N];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      ta[i] = a;
      td[i] = d;
      Req_Addr[5*i +: 5]   = a;
      Req_Data[32*i +: 32] = d;
   endtask

   // Expect requester w granted dc edges after the current negedge
   task automatic expect_grant(input int dc, input int w);
      exp_t e;
      e.cyc  = cyc + dc;
      e.gnt  = 4'b0001 << w;
      e.we   = (ta[w] != 5'd0);
      e.addr = ta[w];
      e.data = td[w];
      sb.push_back(e);
   endtask

   // Monitor: sample just after each rising edge and score any grant/write
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         cyc++;
         if (Gnt != '0 || WE) begin
            if (WE && !$onehot(Gnt)) begin
               n_checks++;
               n_errors++;
               $display("FAIL we_onehot: got WE=1 with Gnt=%b, required one-hot Gnt (cycle %0d)", Gnt, cyc);
            end
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_grant: got Gnt=%b WE=%b, required no grant (cycle %0d)", Gnt, WE, cyc);
            end else begin
               e = sb.pop_front();
               check("grant_cycle", cyc, e.cyc);
               check("gnt", {28'd0, Gnt}, {28'd0, e.gnt});
               check("we", {31'd0, WE}, {31'd0, e.we});
               check("addr", {27'd0, Addr}, {27'd0, e.addr});
               check("data", Data, e.data);
            end
         end
      end
   end

   // Directed stimulus, driven on falling edges
   initial begin
      Rst      = 1'b1;
      Stall    = 1'b0;
      Req      = '0;
      Req_Addr = '0;
      Req_Data = '0;
      for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));

      // Reset overrides held requests
      Req = 4'b1111;
      @(posedge Clk);
      #2;
      check("rst_gnt", {28'd0, Gnt}, 32'd0);
      check("rst_we", {31'd0, WE}, 32'd0);
      check("rst_addr", {27'd0, Addr}, 32'd0);
      check("rst_data", Data, 32'd0);

      // Release: round robin 0,1,2,3,0,1,2,3 back-to-back
      @(negedge Clk);
      Rst = 1'b0;
      for (int k = 0; k < 8; k++) expect_grant(k + 1, k % 4);
      repeat (8) @(negedge Clk);
      Req = '0;
      @(negedge Clk);

      // Single held requester: granted every other cycle
      set_req(2, 5'd5, 32'hF0F0_F0F0);
      Req = 4'b0100;
      expect_grant(1, 2);
      expect_grant(3, 2);
      expect_grant(5, 2);
      repeat (5) @(negedge Clk);
      Req = '0;
      @(negedge Clk);

      // Write to R0: grant issued, WE suppressed, scan resumes at 2
      set_req(1, 5'd0, 32'hFFFF_FFFF);
      Req = 4'b0010;
      expect_grant(1, 1);
      @(negedge Clk);
      set_req(1, 5'd7, 32'h1111_1111);
      Req = 4'b1111;
      expect_grant(1, 2);
      expect_grant(2, 3);
      expect_grant(3, 0);
      expect_grant(4, 1);
      repeat (4) @(negedge Clk);
      Req = '0;
      @(negedge Clk);

      // Stall: grant to 3 brings ptr to 0, stall rises while that grant is high
      Req = 4'b1000;
      expect_grant(1, 3);
      @(negedge Clk);
      Stall = 1'b1;
      Req   = 4'b1001;
      repeat (3) @(negedge Clk);
      Stall = 1'b0;
      expect_grant(1, 0);
      expect_grant(2, 3);
      repeat (2) @(negedge Clk);
      Req = '0;
      @(negedge Clk);

      // Reset while Gnt=0100: grant lost, restart from the lowest requester
      Req = 4'b0110;
      expect_grant(1, 1);
      expect_grant(2, 2);
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #2;
      check("midrst_gnt", {28'd0, Gnt}, 32'd0);
      check("midrst_we", {31'd0, WE}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      expect_grant(1, 1);
      expect_grant(2, 2);
      repeat (2) @(negedge Clk);
      Req = '0;
      repeat (4) @(negedge Clk);

      check("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter that shares the single write port of the 32 x 32-bit register file (built from `register_32bit` cells) among N writeback requesters, e.g. ALU result, memory load and link/PC write. It accepts held requests, issues a one-cycle grant and drives registered WE/Addr/Data straight into the register file. Writes to register 0 are granted but suppressed, keeping R0 hard-wired to zero.

## Interface
- `N`, 4: number of requesters, 2..8.
- `PTR_W`, 2: pointer width, must equal ceil(log2(N)).

- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Req`  in  N  per-requester write request, level, held until granted.
- `Req_Addr`  in  5*N  destination register; requester i on bits [5i+4:5i].
- `Req_Data`  in  32*N  write data; requester i on bits [32i+31:32i].
- `Stall`  in  1  freeze: no new grant while high.
- `Gnt`  out  N  one-hot grant pulse, registered.
- `WE`  out  1  register-file write enable, registered.
- `Addr`  out  5  register-file write address, registered.
- `Data`  out  32  register-file write data, registered.

## Operation
- Internal state: round-robin pointer `ptr` (PTR_W bits, holds 0..N-1). Registered outputs `Gnt`, `WE`, `Addr` and `Data`.
- At each rising edge with `Rst`=0:
  - Eligible set E = `Req` & ~`Gnt` (current registered value). A requester granted in the current cycle is therefore not eligible again in the same cycle.
  - If `Stall`=1 or E=0: `Gnt`<=0, `WE`<=0, `Addr`/`Data` hold, `ptr` unchanged.
  - Otherwise the winner w is the first set bit of E, scanning ptr, ptr+1, ..., wrapping modulo N.
  - Then: `Gnt`<=one-hot(w), `Addr`<=Req_Addr[w], `Data`<=Req_Data[w], `WE`<=(Req_Addr[w]!=0), `ptr`<=(w+1) mod N.
- Write to R0: grant still issued and `ptr` still advances. `WE`=0 and `Addr`=0 are driven; `Data` carries the requester's value but is ignored.
- Requester rules:
  - Hold `Req`, address and data stable until `Gnt[i]`=1 is seen.
  - The request is consumed at the edge that ends the `Gnt` cycle.
  - The requester may drop `Req`, or present a new request with new address/data, in the cycle after `Gnt`.
- A `Req` withdrawn before grant is legal and is simply not served.
- `Req_Addr`/`Req_Data` of requesters that are not requesting are don't-care.
- At most one `Gnt` bit is set in any cycle, and `WE`=1 implies exactly one `Gnt` bit.

## Timing
- Reset values, at the first edge with `Rst`=1: `Gnt`=0, `WE`=0, `Addr`=0, `Data`=0, `ptr`=0.
- `Rst` overrides `Stall` and `Req`.
- Reset mid-grant: `Gnt` and `WE` are cleared at that edge, so the pending write is lost. The requester must re-request after reset.
- Latency, request to grant: `Req` high before edge k with no contention gives `Gnt`/`WE` high for the cycle after edge k.
- Register-file write lands at edge k+1.
- Throughput:
  - One write per cycle while two or more requesters are eligible.
  - A single requester holding `Req` continuously is granted every other cycle, because of the same-cycle mask.
- Fairness: any held request is granted within N grant opportunities. Cycles with `Stall` high do not count as opportunities.
- `Stall` asserted in a cycle where `Gnt` is already high does not cancel that grant. It only blocks the next one.
- Pointer wrap: w=N-1 gives `ptr`<=0.

## Test plan
- Reset: drive `Rst`=1 with `Req`=4'b1111 and `Stall`=0.
  - Required: `Gnt`=0, `WE`=0, `Addr`=0, `Data`=0.
  - After release, the first grant goes to requester 0.
- Single request: requester 2 with `Req_Addr`=5 and `Req_Data`=32'hF0F0F0F0.
  - Required: `Gnt`=4'b0100, `WE`=1, `Addr`=5, `Data`=32'hF0F0F0F0 for exactly one cycle, one cycle after `Req`.
  - If `Req` is held, the pattern repeats every second cycle.
- Round robin: all four requesters held, addresses 1..4.
  - Required: back-to-back grants 0,1,2,3,0,1,... with `WE`=1 every cycle and `Addr` tracking the winner.
- R0 suppression: requester 1 with `Req_Addr`=0 and `Data`=32'hFFFFFFFF.
  - Required: `Gnt`=4'b0010, `WE`=0, `Addr`=0.
  - Next winner scan starts at requester 2.
- Stall: `Stall`=1 for 3 cycles with `Req`=4'b1001 and `ptr`=0.
  - Required: no `Gnt` and `WE`=0 during those cycles.
  - After release, grant 0, then 3.
  - A grant already high when `Stall` rises completes.
- Reset mid-operation: assert `Rst` in the cycle `Gnt`=4'b0100.
  - Required: `Gnt` and `WE` are 0 after that edge, and the first post-reset grant goes to the lowest-index requester still asserting `Req`.
